// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the flexible synchronous FIFO.
//   fifo_mode_e : read-port mode (registered output or first-word-fall-through)
//   ptr_inc     : pointer increment with explicit wrap at depth-1, so any depth
//                 works without relying on power-of-2 address rollover
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: storage array for sync_fifo_flex.
//   clk     in   rising-edge clock
//   wr_en   in   write strobe; wr_data stored at wr_addr on the edge
//   wr_addr in   ADDR_W write address (0..DEPTH-1)
//   wr_data in   DATA_SIZE write data
//   rd_addr in   ADDR_W read address (0..DEPTH-1)
//   rd_data out  DATA_SIZE asynchronous read data
// The array has no reset; the owner tracks which entries hold valid data.
module fifo_regfile #(
  parameter int DEPTH     = 4,
  parameter int DATA_SIZE = 16,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with arbitrary depth, standard or
// first-word-fall-through read port, occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset, highest priority
//   wr_en        in   write request, accepted when not full
//   data_i       in   DATA_SIZE write data
//   full         out  count == DEPTH
//   almost_full  out  count >= AF_THRESH
//   rd_en        in   read request (FWFT: acknowledge/pop of data_o)
//   data_o       out  DATA_SIZE read data (STD: registered; FWFT: head of queue)
//   empty        out  count == 0
//   almost_empty out  count <= AE_THRESH
//   count        out  CNT_W occupancy 0..DEPTH
//   overflow     out  sticky, set by a write request while full
//   underflow    out  sticky, set by a read request while empty
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DATA_SIZE = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 full,
  output logic                 almost_full,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [CNT_W-1:0]     count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  if (DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo_flex: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
    $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 do_wr, do_rd;
  logic [DATA_SIZE-1:0] rd_data;

  // Every status flag is a pure function of the registered occupancy.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept decisions use pre-edge state only: a read never frees space for a
  // same-cycle write when full, and a write never bypasses to a same-cycle
  // read when empty.
  always_comb begin
    do_wr       = wr_en & ~full;
    do_rd       = rd_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);

    if (do_wr) begin
      wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
    end
    if (do_rd) begin
      rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
    end

    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_regfile #(
    .DEPTH     (DEPTH),
    .DATA_SIZE (DATA_SIZE)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr_q),
    .wr_data (data_i),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_SIZE-1:0] data_o_q, data_o_d;

    always_comb begin
      data_o_d = data_o_q;
      if (do_rd) begin
        data_o_d = rd_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_o_q <= '0;
      end else begin
        data_o_q <= data_o_d;
      end
    end

    assign data_o = data_o_q;
  end else begin : g_fwft
    // Head of queue is always visible; meaningful only while not empty.
    assign data_o = rd_data;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Standard-mode instance: DEPTH=5, AF_THRESH=4, AE_THRESH=1
  logic        s_rst, s_wr_en, s_rd_en;
  logic [15:0] s_data_i, s_data_o;
  logic        s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [2:0]  s_count;

  sync_fifo_flex #(.DEPTH(5), .DATA_SIZE(16), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_std (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .data_i(s_data_i), .full(s_full),
    .almost_full(s_af), .rd_en(s_rd_en), .data_o(s_data_o), .empty(s_empty),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  // FWFT instance: DEPTH=5, default thresholds
  logic        f_rst, f_wr_en, f_rd_en;
  logic [15:0] f_data_i, f_data_o;
  logic        f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [2:0]  f_count;

  sync_fifo_flex #(.DEPTH(5), .DATA_SIZE(16), .FWFT(1)) u_fw (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .data_i(f_data_i), .full(f_full),
    .almost_full(f_af), .rd_en(f_rd_en), .data_o(f_data_o), .empty(f_empty),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  logic [15:0] exp_std[$];
  logic [15:0] exp_fw[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_std(input string tag, input int cnt, input logic emp, input logic ful,
                         input logic ae, input logic af, input logic ovf, input logic udf);
    chk({tag, " count"}, 32'(s_count), 32'(cnt));
    chk({tag, " empty"}, 32'(s_empty), 32'(emp));
    chk({tag, " full"}, 32'(s_full), 32'(ful));
    chk({tag, " almost_empty"}, 32'(s_ae), 32'(ae));
    chk({tag, " almost_full"}, 32'(s_af), 32'(af));
    chk({tag, " overflow"}, 32'(s_ovf), 32'(ovf));
    chk({tag, " underflow"}, 32'(s_udf), 32'(udf));
  endtask

  // Stimulus tasks are entered at a falling edge, drive for one rising edge,
  // release the requests just after it and return at the next falling edge.
  task automatic s_cyc(input logic we, input logic [15:0] d, input logic re);
    s_wr_en = we; s_data_i = d; s_rd_en = re;
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic f_cyc(input logic we, input logic [15:0] d, input logic re);
    f_wr_en = we; f_data_i = d; f_rd_en = re;
    @(posedge clk); #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic s_reset(input logic we, input logic [15:0] d);
    s_rst = 1'b1; s_wr_en = we; s_data_i = d;
    @(posedge clk); #1;
    s_rst = 1'b0; s_wr_en = 1'b0;
    exp_std.delete();
    @(negedge clk);
  endtask

  task automatic f_reset();
    f_rst = 1'b1;
    @(posedge clk); #1;
    f_rst = 1'b0;
    exp_fw.delete();
    @(negedge clk);
  endtask

  // STD monitor: an accepted read shows its word on data_o just after the edge.
  initial begin
    logic fire;
    forever begin
      @(negedge clk); #1;
      fire = (s_rst === 1'b0) && (s_rd_en === 1'b1) && (s_empty === 1'b0);
      @(posedge clk); #1;
      if (fire) begin
        n_vec++;
        if (exp_std.size() == 0) begin
          n_err++;
          $display("FAIL std read: got %0h with no word expected at %0t", s_data_o, $time);
        end else begin
          logic [15:0] e;
          e = exp_std.pop_front();
          if (s_data_o !== e) begin
            n_err++;
            $display("FAIL std read: got %0h expected %0h at %0t", s_data_o, e, $time);
          end
        end
      end
    end
  end

  // FWFT monitor: the word being popped is on data_o before the edge.
  initial begin
    forever begin
      @(negedge clk); #1;
      if ((f_rst === 1'b0) && (f_rd_en === 1'b1) && (f_empty === 1'b0)) begin
        n_vec++;
        if (exp_fw.size() == 0) begin
          n_err++;
          $display("FAIL fwft read: got %0h with no word expected at %0t", f_data_o, $time);
        end else begin
          logic [15:0] e;
          e = exp_fw.pop_front();
          if (f_data_o !== e) begin
            n_err++;
            $display("FAIL fwft read: got %0h expected %0h at %0t", f_data_o, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst = 1'b1; s_wr_en = 1'b0; s_rd_en = 1'b0; s_data_i = '0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_data_i = '0;
    @(negedge clk);

    // ---------------- standard mode ----------------
    s_reset(1'b0, '0);
    chk_std("std reset", 0, 1, 0, 1, 0, 0, 0);
    chk("std reset data_o", 32'(s_data_o), 32'h0);

    for (int i = 0; i < 3; i++) begin
      s_cyc(1'b1, 16'(16'hA0 + i), 1'b0);
      exp_std.push_back(16'(16'hA0 + i));
    end
    chk_std("fill3", 3, 0, 0, 0, 0, 0, 0);
    s_cyc(1'b1, 16'hA3, 1'b0); exp_std.push_back(16'hA3);
    chk_std("fill4", 4, 0, 0, 0, 1, 0, 0);
    s_cyc(1'b1, 16'hA4, 1'b0); exp_std.push_back(16'hA4);
    chk_std("fill5", 5, 0, 1, 0, 1, 0, 0);
    s_cyc(1'b1, 16'hA5, 1'b0);
    chk_std("overflow", 5, 0, 1, 0, 1, 1, 0);

    for (int i = 0; i < 5; i++) s_cyc(1'b0, '0, 1'b1);
    chk_std("drained", 0, 1, 0, 1, 0, 1, 0);
    chk("drained data_o holds last", 32'(s_data_o), 32'hA4);
    s_cyc(1'b0, '0, 1'b1);
    chk_std("underflow", 0, 1, 0, 1, 0, 1, 1);

    // 13 writes through a 5-deep array wrap both pointers twice.
    s_reset(1'b0, '0);
    s_cyc(1'b1, 16'hB00, 1'b0); exp_std.push_back(16'hB00);
    for (int i = 1; i <= 12; i++) begin
      s_cyc(1'b1, 16'(16'hB00 + i), 1'b1);
      exp_std.push_back(16'(16'hB00 + i));
      chk("pair count", 32'(s_count), 32'd1);
    end
    s_cyc(1'b0, '0, 1'b1);
    chk_std("pairs drained", 0, 1, 0, 1, 0, 0, 0);

    // Full with simultaneous read and write.
    for (int i = 0; i < 5; i++) begin
      s_cyc(1'b1, 16'(16'hC0 + i), 1'b0);
      exp_std.push_back(16'(16'hC0 + i));
    end
    s_cyc(1'b1, 16'hC5, 1'b1);
    chk_std("full both", 4, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) s_cyc(1'b0, '0, 1'b1);
    chk_std("full both drained", 0, 1, 0, 1, 0, 1, 0);

    // Empty with simultaneous read and write.
    s_reset(1'b0, '0);
    s_cyc(1'b1, 16'hD0, 1'b1); exp_std.push_back(16'hD0);
    chk_std("empty both", 1, 0, 0, 1, 0, 0, 1);
    s_cyc(1'b0, '0, 1'b1);
    chk_std("empty both drained", 0, 1, 0, 1, 0, 0, 1);

    // Reset in the middle of filling, with a write on the reset edge.
    s_reset(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      s_cyc(1'b1, 16'(16'hE0 + i), 1'b0);
      exp_std.push_back(16'(16'hE0 + i));
    end
    chk("midfill af at 3", 32'(s_af), 32'd0);
    s_cyc(1'b1, 16'hE3, 1'b0); exp_std.push_back(16'hE3);
    chk("midfill af at 4", 32'(s_af), 32'd1);
    s_reset(1'b1, 16'hE4);
    chk_std("midfill reset", 0, 1, 0, 1, 0, 0, 0);
    chk("midfill reset data_o", 32'(s_data_o), 32'h0);
    chk("std scoreboard empty", 32'(exp_std.size()), 32'd0);

    // ---------------- first-word-fall-through ----------------
    f_reset();
    chk("fw reset empty", 32'(f_empty), 32'd1);
    chk("fw reset count", 32'(f_count), 32'd0);
    f_cyc(1'b1, 16'h1234, 1'b0); exp_fw.push_back(16'h1234);
    chk("fw fallthrough empty", 32'(f_empty), 32'd0);
    chk("fw fallthrough data", 32'(f_data_o), 32'h1234);
    f_cyc(1'b0, '0, 1'b1);
    chk("fw popped empty", 32'(f_empty), 32'd1);

    f_cyc(1'b1, 16'h1111, 1'b0); exp_fw.push_back(16'h1111);
    f_cyc(1'b1, 16'h2222, 1'b0); exp_fw.push_back(16'h2222);
    f_cyc(1'b1, 16'h3333, 1'b0); exp_fw.push_back(16'h3333);
    chk("fw count 3", 32'(f_count), 32'd3);
    f_cyc(1'b1, 16'h4444, 1'b1); exp_fw.push_back(16'h4444);
    chk("fw both count", 32'(f_count), 32'd3);
    chk("fw head after pop", 32'(f_data_o), 32'h2222);
    for (int i = 0; i < 3; i++) f_cyc(1'b0, '0, 1'b1);
    chk("fw drained empty", 32'(f_empty), 32'd1);
    chk("fw overflow", 32'(f_ovf), 32'd0);
    chk("fw underflow", 32'(f_udf), 32'd0);
    chk("fw scoreboard empty", 32'(exp_fw.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
